// File: rtl/led_chase_monitor_if.sv
// led_chase_monitor_if: bus between an LED chase source and its monitor.
//   en, led            : monitor enable and observed LED bus (source -> monitor)
//   pos, step_pulse    : one-hot index and per-step pulse (monitor -> source)
//   period, freq_code,
//   freq_valid, locked : measured step period, its decode and the lock flag
//   err_pulse, err_cnt : per-error pulse and saturating error count
interface led_chase_monitor_if;
  logic        en;
  logic [7:0]  led;
  logic [2:0]  pos;
  logic        step_pulse;
  logic [31:0] period;
  logic [1:0]  freq_code;
  logic        freq_valid;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
  modport master (
    output en, led,
    input  pos, step_pulse, period, freq_code, freq_valid, locked, err_pulse, err_cnt
  );
  modport slave (
    input  en, led,
    output pos, step_pulse, period, freq_code, freq_valid, locked, err_pulse, err_cnt
  );
endinterface

// File: rtl/led_chase_monitor.sv
// led_chase_monitor: measures and checks a one-hot rotating LED chase.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   bus        : led_chase_monitor_if.slave (en/led in, status out)
//   BASE_TICKS : step period in clk cycles for freq code 2'b00
//   LED_MON_ERRCNT_EN : when defined, err_cnt counts err_pulse (saturating);
//                       otherwise err_cnt is tied to zero
module led_chase_monitor #(
  parameter int unsigned BASE_TICKS = 10_000_000
) (
  input logic clk,
  input logic rst,
  led_chase_monitor_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SYNC = 2'd1;
  localparam logic [1:0] LOCK = 2'd2;
  localparam logic [31:0] B1  = 32'(BASE_TICKS);
  localparam logic [31:0] B2  = 32'(BASE_TICKS) * 32'd2;
  localparam logic [31:0] B5  = 32'(BASE_TICKS) * 32'd5;
  localparam logic [31:0] B10 = 32'(BASE_TICKS) * 32'd10;
  logic [1:0]  state, nxt;
  logic [7:0]  led_q;
  logic [31:0] cnt;
  logic [2:0]  idx;
  logic        chg, legal_val, legal_step, step, stall, err, dec_valid;
  logic [1:0]  dec_code;
  assign chg        = bus.led != led_q;
  assign legal_val  = bus.led != 8'h00 && (bus.led & (bus.led - 8'd1)) == 8'h00;
  assign legal_step = legal_val && (led_q == 8'h80 ? bus.led == 8'h01 : bus.led == led_q << 1);
  // a step arriving together with en falling is dropped
  assign step       = legal_step && bus.en;
  // cnt is the cycle count since the last change, so it is the candidate period
  assign stall      = !chg && {1'b0, cnt} > {1'b0, bus.period} + 33'd1;
  assign dec_valid  = cnt == B1 || cnt == B2 || cnt == B5 || cnt == B10;
  assign dec_code   = cnt == B2 ? 2'b01 : cnt == B5 ? 2'b10 : cnt == B10 ? 2'b11 : 2'b00;
  assign err        = bus.en && state != IDLE && (!legal_val || (chg && !legal_step) ||
                      (state == LOCK && ((step && cnt != bus.period) || stall)));
  assign bus.locked = state == LOCK;
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) idx = bus.led[i] ? 3'(i) : idx;
  end
  always_comb begin
    nxt = (!bus.en || err) ? IDLE : !step ? state : state == IDLE ? SYNC :
          (cnt == bus.period && dec_valid) ? LOCK : SYNC;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      led_q          <= 8'h01;
      cnt            <= 32'd1;
      bus.pos        <= 3'd0;
      bus.period     <= 32'd0;
      bus.freq_code  <= 2'b00;
      bus.freq_valid <= 1'b0;
      bus.step_pulse <= 1'b0;
      bus.err_pulse  <= 1'b0;
    end else begin
      state          <= nxt;
      led_q          <= bus.led;
      cnt            <= chg ? 32'd1 : (&cnt ? cnt : cnt + 32'd1);
      bus.step_pulse <= step;
      bus.err_pulse  <= err;
      if (legal_val) bus.pos <= idx;
      if (step) begin
        bus.period     <= cnt;
        bus.freq_valid <= dec_valid;
        if (dec_valid) bus.freq_code <= dec_code;
      end
    end
  end
`ifdef LED_MON_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.err_cnt <= 16'h0000;
    else if (err && !(&bus.err_cnt)) bus.err_cnt <= bus.err_cnt + 16'd1;
  end
`else
  assign bus.err_cnt = 16'h0000;
`endif
endmodule
